// File: rtl/lane_sched_pkg.sv
// Shared types, constants and the round-robin pick function for the lane scheduler.
package lane_sched_pkg;

    localparam int N_LANES = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } pick_t;

    function automatic pick_t rr_pick(input logic [N_LANES-1:0] req,
                                      input logic [SEL_W-1:0]   ptr);
        pick_t            pick;
        logic [SEL_W-1:0] lane;
        pick = '0;
        // Scan from the farthest offset down, so the lane nearest ptr is written last and wins.
        for (int off = N_LANES - 1; off >= 0; off--) begin
            lane = ptr + SEL_W'(off);
            if (req[lane]) begin
                pick.found = 1'b1;
                pick.idx   = lane;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/lane_sel_mux4.sv
// 4:1 lane-select mux with enable; output is forced low while disabled.
module lane_sel_mux4
    import lane_sched_pkg::*;
(
    input  logic [N_LANES-1:0] data,
    input  logic [SEL_W-1:0]   sel,
    input  logic               en,
    output logic               out
);

    // NOTE: every path assigns out, so no latch is inferred.
    always_comb begin
        out = en ? data[sel] : 1'b0;
    end

endmodule

// File: rtl/lane_rr_scheduler.sv
// Round-robin scheduler granting the shared lane mux to one of four lanes for HOLD_CYCLES cycles.
module lane_rr_scheduler
    import lane_sched_pkg::*;
#(
    parameter int HOLD_CYCLES = 2
)(
    input  logic               clk,
    input  logic               rst,
    input  logic [N_LANES-1:0] req,
    input  logic [N_LANES-1:0] data,
    output logic [SEL_W-1:0]   sel,
    output logic               flag,
    output logic [N_LANES-1:0] grant,
    output logic [N_LANES-1:0] ack,
    output logic               busy,
    output logic               valid_data
);

    localparam int               CNT_W    = $clog2(HOLD_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last;
    logic [SEL_W-1:0] arb_ptr;
    pick_t            pick;

    // On the last hold cycle the pointer advance and the scan share one edge.
    assign last    = (state_q == HOLD) && (cnt_q == '0);
    assign arb_ptr = last ? sel_q + SEL_W'(1) : ptr_q;
    assign pick    = rr_pick(req, arb_ptr);

    // NOTE: defaults first keep every next-state signal fully assigned.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (pick.found) begin
                    sel_d   = pick.idx;
                    cnt_d   = CNT_LOAD;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    ptr_d = sel_q + SEL_W'(1);
                    if (pick.found) begin
                        sel_d = pick.idx;
                        cnt_d = CNT_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sel   = sel_q;
    assign flag  = (state_q == HOLD);
    assign busy  = flag;
    assign grant = flag ? (N_LANES'(1) << sel_q) : '0;
    assign ack   = last ? (N_LANES'(1) << sel_q) : '0;

    lane_sel_mux4 u_mux (
        .data (data),
        .sel  (sel_q),
        .en   (flag),
        .out  (valid_data)
    );

endmodule

// File: tb/tb_lane_rr_scheduler.sv
// Self-checking bench: three scheduler instances (HOLD_CYCLES 1,2,3) against a transaction-level model.
module tb_lane_rr_scheduler;

    localparam int NI = 3;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [3:0]            req;
    logic [3:0]            data;
    logic [NI-1:0][1:0]    sel;
    logic [NI-1:0]         flag;
    logic [NI-1:0][3:0]    grant;
    logic [NI-1:0][3:0]    ack;
    logic [NI-1:0]         busy;
    logic [NI-1:0]         valid_data;

    int hold_of [NI] = '{1, 2, 3};

    // Model: is a grant running, to which lane, how many cycles remain, where the pointer is.
    int m_busy [NI];
    int m_lane [NI];
    int m_left [NI];
    int m_ptr  [NI];
    int m_sel  [NI];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    lane_rr_scheduler #(.HOLD_CYCLES(1)) u_h1 (
        .clk(clk), .rst(rst), .req(req), .data(data),
        .sel(sel[0]), .flag(flag[0]), .grant(grant[0]), .ack(ack[0]),
        .busy(busy[0]), .valid_data(valid_data[0])
    );

    lane_rr_scheduler #(.HOLD_CYCLES(2)) u_h2 (
        .clk(clk), .rst(rst), .req(req), .data(data),
        .sel(sel[1]), .flag(flag[1]), .grant(grant[1]), .ack(ack[1]),
        .busy(busy[1]), .valid_data(valid_data[1])
    );

    lane_rr_scheduler #(.HOLD_CYCLES(3)) u_h3 (
        .clk(clk), .rst(rst), .req(req), .data(data),
        .sel(sel[2]), .flag(flag[2]), .grant(grant[2]), .ack(ack[2]),
        .busy(busy[2]), .valid_data(valid_data[2])
    );

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [3:0] e_grant;
        logic       e_vd;
        for (int i = 0; i < NI; i++) begin
            e_grant = (m_busy[i] != 0) ? 4'(1 << m_lane[i]) : 4'b0000;
            e_vd    = (m_busy[i] != 0) ? data[m_lane[i]] : 1'b0;
            check($sformatf("h%0d flag", hold_of[i]),  4'(flag[i]),  4'(m_busy[i] != 0));
            check($sformatf("h%0d busy", hold_of[i]),  4'(busy[i]),  4'(m_busy[i] != 0));
            check($sformatf("h%0d grant", hold_of[i]), grant[i],     e_grant);
            check($sformatf("h%0d ack", hold_of[i]),   ack[i],
                  (m_busy[i] != 0 && m_left[i] == 1) ? e_grant : 4'b0000);
            check($sformatf("h%0d sel", hold_of[i]),   4'(sel[i]),   4'(m_sel[i]));
            check($sformatf("h%0d valid_data", hold_of[i]), 4'(valid_data[i]), 4'(e_vd));
        end
    endtask

    // Advance the model by one rising edge given the sampled req/rst.
    task automatic model_edge(input logic [3:0] r, input logic rs);
        int lane;
        bit found;
        for (int i = 0; i < NI; i++) begin
            if (rs) begin
                m_busy[i] = 0; m_lane[i] = 0; m_left[i] = 0; m_ptr[i] = 0; m_sel[i] = 0;
            end else begin
                if (m_busy[i] != 0) begin
                    m_left[i]--;
                    if (m_left[i] == 0) begin
                        m_ptr[i]  = (m_lane[i] + 1) % 4;
                        m_busy[i] = 0;
                    end
                end
                if (m_busy[i] == 0 && r != 4'b0000) begin
                    found = 1'b0;
                    for (int off = 0; off < 4; off++) begin
                        lane = (m_ptr[i] + off) % 4;
                        if (!found && r[lane]) begin
                            found     = 1'b1;
                            m_busy[i] = 1;
                            m_lane[i] = lane;
                            m_sel[i]  = lane;
                            m_left[i] = hold_of[i];
                        end
                    end
                end
            end
        end
    endtask

    // One cycle: drive inputs, check outputs mid-cycle, take the edge, return at the falling edge.
    task automatic step(input logic [3:0] r, input logic rs);
        req  = r;
        rst  = rs;
        data = 4'($urandom_range(0, 15));
        #1;
        check_all();
        @(posedge clk);
        model_edge(r, rs);
        @(negedge clk);
    endtask

    task automatic steps(input logic [3:0] r, input int n);
        for (int k = 0; k < n; k++) step(r, 1'b0);
    endtask

    initial begin
        logic [3:0] r;
        rst  = 1'b1;
        req  = 4'b0000;
        data = 4'b0000;
        @(posedge clk);
        model_edge(4'b0000, 1'b1);
        @(negedge clk);

        // Idle after reset: all outputs stay low.
        steps(4'b0000, 10);

        // Single request from lane 2, then withdrawn.
        step(4'b0100, 1'b0);
        steps(4'b0000, 5);

        // All lanes requesting continuously.
        steps(4'b1111, 12);
        steps(4'b0000, 4);

        // Serve lane 1 so the pointer sits at 2, then 1011.
        step(4'b0000, 1'b1);
        step(4'b0010, 1'b0);
        steps(4'b0000, 5);
        steps(4'b1011, 14);
        steps(4'b0000, 4);

        // Reset in the second cycle of a grant, then a fresh lane-0 request.
        step(4'b0000, 1'b1);
        step(4'b0100, 1'b0);
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b1);
        step(4'b0001, 1'b0);
        steps(4'b0000, 5);

        // Two lanes held: alternation with back-to-back grants.
        steps(4'b0011, 10);
        steps(4'b0000, 4);

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 400; k++) begin
            r = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            step(r, ($urandom_range(0, 49) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lane_rr_scheduler.md
# lane_rr_scheduler

- Round-robin scheduler that shares the 4:1 lane-select mux among four requesting lanes.
- Arbitrates the `req` lines and drives the mux select and enable for a fixed number of cycles per grant.
- Acknowledges each served lane and presents the selected lane's data bit as `valid_data`.
- Sits between the lane request logic and the downstream bit consumer; the mux itself is instantiated inside.

## Interface
- `HOLD_CYCLES`, default 2: cycles each grant is held. Legal range 1..16.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in 4: per-lane request; level-sensitive and sampled every edge.
- `data` in 4: per-lane data bits, fed straight to the mux.
- `sel` out 2: registered select to the mux, equal to the index of the granted lane.
- `flag` out 1: registered mux enable; high only while a grant is active.
- `grant` out 4: one-hot granted lane; all zero when idle.
- `ack` out 4: one-hot pulse during the final cycle of a grant.
- `busy` out 1: equals `flag`.
- `valid_data` out 1: mux output. Equals `data[sel]` when `flag`=1, else 0.

## Operation
- Reset values: `sel`=0, `flag`=0, `grant`=0, `ack`=0, `busy`=0, `valid_data`=0. The internal priority pointer `ptr` resets to 0, the state to IDLE and the hold counter to 0.
- Reset mid-grant aborts the grant, emits no `ack`, and brings all outputs to reset values after that edge.
- States:
  - IDLE: `flag`=0. If `req`≠0 at an edge, arbitrate, load `sel`/`grant`, set `cnt`=HOLD_CYCLES-1, go to HOLD. Otherwise stay in IDLE.
  - HOLD: `flag`=1, `grant`=onehot(`sel`).
    - If `cnt`≠0: decrement `cnt`.
    - If `cnt`=0 (last cycle): `ack`=onehot(`sel`) combinationally, and `ptr`←`sel`+1 (mod 4) at the edge.
    - If `cnt`=0 and `req`≠0: re-arbitrate in the same edge, using the updated pointer (`sel`+1), and stay in HOLD. Back-to-back grants have no bubble.
    - If `cnt`=0 and `req`=0: go to IDLE.
- Arbitration: the winner is the first set bit of `req` scanning upward from `ptr`, wrapping 3→0. The pointer update and the scan happen in the same edge, so the just-served lane has the lowest priority.
- A lane requesting continuously alone is re-granted back-to-back.
- Request withdrawal during HOLD does not shorten the grant; the full HOLD_CYCLES run and `ack` still fires.
- New requests arriving during HOLD wait for the end of the grant; there is no preemption.
- With HOLD_CYCLES=1, `cnt` stays 0 and every HOLD cycle is a last cycle, so `ack` can pulse every cycle.
- `cnt` width: $clog2(HOLD_CYCLES)+1 bits, no wrap. It never underflows because it is reloaded whenever it reaches 0.

## Timing
- `req` sampled high in IDLE at edge *t*: `sel`/`flag`/`grant` are valid in cycle *t*+1.
- Grant duration is exactly HOLD_CYCLES cycles. `ack` is asserted in cycle *t*+HOLD_CYCLES.
- Next grant starts in cycle *t*+HOLD_CYCLES+1 if `req`≠0 at the final edge. Otherwise there is a minimum one IDLE cycle.
- `valid_data` is combinational from `data` and the registered `sel`/`flag`; there is no data-path latency.
- Worst-case wait for a requesting lane: 3×HOLD_CYCLES cycles after the current grant ends.

## Structure
- Shared package `lane_sched_pkg`:
  - state encoding (IDLE=1'b0, HOLD=1'b1)
  - `N_LANES`=4
  - `SEL_W`=2
  - function `rr_pick(req, ptr)` returning index and found bit
- One sub-module, `lane_sel_mux4`: data[3:0], sel[1:0], en → out 0 when en=0. It is instantiated once, driven by `sel`/`flag`.
- Everything else lives in a single always block for state/counter/pointer, plus combinational arbitration and `ack`.

## Test plan
- Reset then `req`=0000 for 10 cycles: all outputs stay 0 and `busy`=0 throughout.
- HOLD_CYCLES=2, `req`=0100 for one cycle then 0: `sel`=2 and `grant`=0100 for 2 cycles, `ack`=0100 in the 2nd, back to IDLE; `valid_data` follows `data[2]`.
- HOLD_CYCLES=2, `req`=1111 held: grants 0,1,2,3,0 with no gaps, each 2 cycles, and one `ack` per grant.
- `ptr`=2 after serving lane 1, then `req`=1011: lane 3 is granted before lane 0, then lane 0, then lane 1.
- HOLD_CYCLES=3, `rst` asserted in the 2nd cycle of a grant: the next cycle shows all outputs 0 and no `ack`; a following `req`=0001 is granted normally with `ptr` restarted at 0.
- HOLD_CYCLES=1, `req`=0011 held: `sel` alternates 0,1,0,1 each cycle, `ack` pulses every cycle, and `flag` stays 1.
